// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetch requests, tracks in-flight
// reads with a credit scheme, buffers returned words in a small FIFO and hands
// them to decode. Redirects flush the FIFO and drop stale responses.
// Optional delivered-instruction counter enabled by macro IFU_FETCH_COUNT_EN.
// BUF_DEPTH must be 2 or 4 (pointers wrap naturally at a power of two).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] fetch_count
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] DepthC = (CW + 1)'(BUF_DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q;
  logic [31:0]     fetch_pc_q;
  logic [31:0]     rsp_pc_q;
  logic [CW-1:0]   out_q;
  logic [CW-1:0]   out_d;
  logic [CW-1:0]   drop_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [31:0]     buf_instr_q [BUF_DEPTH];
  logic [31:0]     buf_pc_q    [BUF_DEPTH];

  logic        req_hs;
  logic        pop;
  logic        push;
  logic        credit_ok;
  logic [31:0] redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

  // Requests in flight plus buffered words never exceed the buffer size, so
  // every response has a slot waiting for it.
  assign credit_ok      = ({1'b0, out_q} + {1'b0, cnt_q}) < DepthC;
  assign imem_req_valid = (state_q == StRun) && en && !redirect_valid && credit_ok;
  assign imem_addr      = fetch_pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign if_valid = (cnt_q != '0);
  assign if_instr = buf_instr_q[rd_ptr_q];
  assign if_pc    = buf_pc_q[rd_ptr_q];
  assign pop      = if_valid && if_ready;

  // A response arriving with a redirect, or while stale reads remain, is dropped.
  assign push = imem_rsp_valid && !redirect_valid && (drop_q == '0);

  // Next outstanding count after this cycle's request handshake and response.
  always_comb begin
    out_d = out_q;
    case ({req_hs, imem_rsp_valid})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
  end

  // Run/idle state follows fetch enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle:  if (en)  state_q <= StRun;
        StRun:   if (!en) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Fetch and response PCs; both jump to the aligned target on redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_pc_aligned;
      rsp_pc_q   <= redirect_pc_aligned;
    end else begin
      if (req_hs) fetch_pc_q <= fetch_pc_q + 32'd4;
      if (push)   rsp_pc_q   <= rsp_pc_q + 32'd4;
    end
  end

  // Outstanding reads and the number of them still to be discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      out_q <= out_d;
      if (redirect_valid) begin
        drop_q <= out_d;
      end else if (imem_rsp_valid && (drop_q != '0)) begin
        drop_q <= drop_q - CW'(1);
      end
    end
  end

  // Prefetch buffer pointers and occupancy; redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Buffer storage; contents are qualified by occupancy so need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rsp_data;
      buf_pc_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

`ifdef IFU_FETCH_COUNT_EN
  logic [31:0] fetch_count_q;

  // Delivered-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else if (pop) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule
